dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the pipelined ARM core's memory stage and a secondary DMA/loader port. It sits between the core's data port (`MemWrite`/`DataAdr`/`WriteData`/`ReadData`) and `dmem`. It grants one access per cycle, stalls the core when the DMA side wins a contested cycle, and returns DMA read data through a registered valid pulse. A bounded-share counter guarantees neither side starves.

## Interface
Parameters:
- `CPU_SHARE`, default 3: contested cycles the CPU wins before the DMA is forced one grant (1..15).
- `AW`, default 32: address width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_re`  in  1  core memory-stage load request.
- `cpu_we`  in  1  core memory-stage store request (`MemWrite`).
- `cpu_adr`  in  AW  core byte address (`DataAdr`).
- `cpu_wd`  in  32  core store data (`WriteData`).
- `cpu_rd`  out  32  load data to the core, combinational from `mem_rd`.
- `cpu_stall`  out  1  freeze request, ORed into the hazard unit's StallF/StallD/StallE/StallM.
- `dma_req`  in  1  DMA access request; held until granted.
- `dma_we`  in  1  1 = write, 0 = read; qualified by `dma_req`.
- `dma_adr`  in  AW  DMA byte address.
- `dma_wd`  in  32  DMA write data.
- `dma_gnt`  out  1  DMA access accepted this cycle (combinational).
- `dma_rdata`  out  32  registered DMA read data.
- `dma_rvalid`  out  1  one-cycle pulse; `dma_rdata` is valid.
- `mem_we`  out  1  to dmem write enable.
- `mem_adr`  out  AW  to dmem address.
- `mem_wd`  out  32  to dmem write data.
- `mem_rd`  in  32  from dmem, combinational read of `mem_adr`.

## Operation
- `cpu_req = cpu_re | cpu_we`. Only one of `cpu_gnt` (internal) and `dma_gnt` is high in any cycle.
- Grant rules, evaluated combinationally each cycle:
  - Neither side requests: no grant, `mem_we=0`, `mem_adr=cpu_adr`.
  - Exactly one side requests: that side is granted.
  - Both request (contested): if `share_cnt < CPU_SHARE`, the CPU is granted. Otherwise the DMA is granted.
- `share_cnt` is a 4-bit register, reset 0:
  - Contested and CPU granted: increment.
  - Contested and DMA granted: clear to 0.
  - Uncontested DMA grant: clear to 0.
  - Uncontested CPU grant or idle cycle: hold.
- Mux: the granted side drives `mem_adr`, `mem_wd`, and `mem_we` (`cpu_we` or `dma_we`). `cpu_rd = mem_rd` always. It is meaningful only when the CPU is granted.
- `cpu_stall = cpu_req & ~cpu_gnt`. A stalled core holds its request unchanged, so the access retries next cycle.
- DMA read handshake:
  - On a rising edge with `dma_gnt & ~dma_we`, `dma_rdata <= mem_rd` and `dma_rvalid <= 1`.
  - Otherwise `dma_rvalid <= 0` and `dma_rdata` holds.
- DMA write: complete at the edge where `dma_gnt=1`. No response.
- Simultaneous CPU write and DMA access to the same address: the granted side's access happens that cycle. The loser sees the updated memory on its later grant.

## Timing
- Reset values: `share_cnt=0`, `dma_rvalid=0`, `dma_rdata=0`. Combinational outputs follow their inputs during reset.
- CPU access latency 0. Same-cycle read data preserves the existing pipeline timing with no added stages.
- DMA read latency 1: grant in cycle N, `dma_rvalid`/`dma_rdata` in cycle N+1.
- Worst-case CPU stall: 1 consecutive cycle per `CPU_SHARE+1` contested cycles.
- Worst-case DMA wait under continuous CPU traffic: `CPU_SHARE` cycles.
- Reset asserted in the cycle after a DMA read grant: `dma_rvalid` stays 0 and the response is dropped. The DMA re-issues after reset.
- `dma_req` deasserted before grant: no access and no counter change.

## Test plan
- Reset: hold `reset=1` for 2 cycles with both requests active. Required: `dma_rvalid=0`, `dma_rdata=0`. The first contested cycle after release grants the CPU.
- CPU-only store: `cpu_we=1`, `cpu_adr=0x64`, `cpu_wd=7`. Required: same cycle `mem_we=1`, `mem_adr=0x64`, `mem_wd=7`, `cpu_stall=0`, `dma_gnt=0`.
- DMA-only read after that store: `dma_req=1`, `dma_we=0`, `dma_adr=0x64` in cycle N. Required: `dma_gnt=1` in N; `dma_rvalid=1`, `dma_rdata=7` in N+1; `dma_rvalid=0` in N+2.
- Continuous contention with `CPU_SHARE=3` and both requests held high for 12 cycles. Required: grant pattern C,C,C,D repeating three times, `cpu_stall=1` exactly in cycles 4, 8, 12.
- Same-address race: DMA write 0x55 to 0x80 while the core loads 0x80 with `share_cnt=3`. Required: DMA is granted and the CPU stalls one cycle. The next cycle the CPU is granted and `cpu_rd=0x55`.
- Reset mid-operation: DMA read granted in cycle N, `reset=1` in N+1. Required: `dma_rvalid=0` in N+1 and N+2, `share_cnt` back to 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core's memory stage and a
//   DMA/loader port. One access per cycle; the core is stalled when the DMA
//   wins a contested cycle. A bounded-share counter forces a DMA grant after
//   CPU_SHARE consecutive contested CPU wins, so neither side starves.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_re, cpu_we             core load / store request
//   cpu_adr, cpu_wd            core byte address / store data
//   cpu_rd                     load data to core (combinational from mem_rd)
//   cpu_stall                  core freeze request
//   dma_req, dma_we            DMA request (held until granted), 1 = write
//   dma_adr, dma_wd            DMA byte address / write data
//   dma_gnt                    DMA access accepted this cycle
//   dma_rdata, dma_rvalid      registered DMA read data and one-cycle valid
//   mem_we, mem_adr, mem_wd    to dmem
//   mem_rd                     from dmem, combinational read of mem_adr
module dmem_arbiter #(
  parameter int unsigned CPU_SHARE = 3,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [31:0]   cpu_wd,
  output logic [31:0]   cpu_rd,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [31:0]   dma_wd,
  output logic          dma_gnt,
  output logic [31:0]   dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  localparam logic [3:0] SHARE_LIM = 4'(CPU_SHARE);

  logic       cpu_req;
  logic       contested;
  logic       cpu_gnt;
  logic [3:0] share_cnt;
  logic       rvalid_q;

  always_comb begin
    cpu_req   = cpu_re | cpu_we;
    contested = cpu_req & dma_req;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    if (contested) begin
      if (share_cnt < SHARE_LIM) cpu_gnt = 1'b1;
      else                       dma_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req;
    end
  end

  always_comb begin
    mem_adr   = dma_gnt ? dma_adr : cpu_adr;
    mem_wd    = dma_gnt ? dma_wd  : cpu_wd;
    mem_we    = cpu_gnt ? cpu_we : (dma_gnt & dma_we);
    cpu_rd    = mem_rd;
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      share_cnt <= '0;
      rvalid_q  <= 1'b0;
      dma_rdata <= '0;
    end else begin
      if (dma_gnt)        share_cnt <= '0;
      else if (contested) share_cnt <= share_cnt + 4'd1;
      rvalid_q <= dma_gnt & ~dma_we;
      if (dma_gnt & ~dma_we) dma_rdata <= mem_rd;
    end
  end

  // Masking with reset drops a response whose valid cycle coincides with
  // reset, so a read granted just before reset never reports valid.
  assign dma_rvalid = rvalid_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned SHARE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_adr, dma_wd;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.CPU_SHARE(SHARE), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Data memory environment: combinational read, write on rising edge.
  logic [31:0] mem [256] = '{default: '0};
  assign mem_rd = mem[mem_adr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_adr[9:2]] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic cre, input logic cwe,
                       input logic [31:0] cadr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe,
                       input logic [31:0] dadr, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    reset = rst; cpu_re = cre; cpu_we = cwe; cpu_adr = cadr; cpu_wd = cwd;
    dma_req = dreq; dma_we = dwe; dma_adr = dadr; dma_wd = dwd;
  endtask

  typedef struct {
    logic rst, cre, cwe; logic [31:0] cadr, cwd;
    logic dreq, dwe; logic [31:0] dadr, dwd;
    logic e_dgnt, e_stall, e_mwe; logic [31:0] e_madr, e_mwd;
    logic chk_rd; logic [31:0] e_rd;
    logic e_rv; logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      logic rst, logic cre, logic cwe, logic [31:0] cadr, logic [31:0] cwd,
      logic dreq, logic dwe, logic [31:0] dadr, logic [31:0] dwd,
      logic e_dgnt, logic e_stall, logic e_mwe, logic [31:0] e_madr, logic [31:0] e_mwd,
      logic chk_rd, logic [31:0] e_rd, logic e_rv, logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.cre = cre; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dadr = dadr; v.dwd = dwd;
    v.e_dgnt = e_dgnt; v.e_stall = e_stall; v.e_mwe = e_mwe;
    v.e_madr = e_madr; v.e_mwd = e_mwd; v.chk_rd = chk_rd; v.e_rd = e_rd;
    v.e_rv = e_rv; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference model state
  int          wins;        // consecutive contested CPU wins since last DMA grant
  logic        m_rv;
  logic [31:0] m_rdata;
  logic [31:0] refmem [256];
  int          dma_wait;

  initial begin
    reset = 1'b1; cpu_re = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_adr = '0; dma_wd = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- table-driven directed vectors ----------------
    // reset held two cycles with both sides requesting
    tbl.push_back(mk(1,1,0,32'h20,0, 1,0,32'h10,0, 0,0,0,32'h20,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,0,32'h20,0, 1,0,32'h10,0, 0,0,0,32'h20,0, 0,0, 0,0));
    // first contested cycle after reset grants the CPU
    tbl.push_back(mk(0,1,0,32'h20,0, 1,0,32'h10,0, 0,0,0,32'h20,0, 0,0, 0,0));
    // CPU-only store 7 -> 0x64
    tbl.push_back(mk(0,0,1,32'h64,7, 0,0,0,0, 0,0,1,32'h64,7, 0,0, 0,0));
    // DMA-only read of 0x64, response next cycle, then valid drops
    tbl.push_back(mk(0,0,0,32'h04,0, 1,0,32'h64,0, 1,0,0,32'h64,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,32'h04,0, 0,0,0,0, 0,0,0,32'h04,0, 0,0, 1,7));
    tbl.push_back(mk(0,0,0,32'h04,0, 0,0,0,0, 0,0,0,32'h04,0, 0,0, 0,7));
    // 12 contested cycles: C,C,C,D x3
    for (int j = 0; j < 12; j++) begin
      logic dw;
      dw = (j % 4 == 3);
      tbl.push_back(mk(0,1,0,32'h08,0, 1,0,32'h64,0,
                       dw, dw, 0, dw ? 32'h64 : 32'h08, 0,
                       !dw, 0, (j % 4 == 0) && (j > 0), 7));
    end
    // build share_cnt up to 3 (first of these still sees the last DMA response)
    tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h64,0, 0,0,0,32'h40,0, 1,0, 1,7));
    tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h64,0, 0,0,0,32'h40,0, 1,0, 0,7));
    tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h64,0, 0,0,0,32'h40,0, 1,0, 0,7));
    // same-address race: DMA writes 0x55 to 0x80, CPU load of 0x80 stalls
    tbl.push_back(mk(0,1,0,32'h80,0, 1,1,32'h80,32'h55, 1,1,1,32'h80,32'h55, 0,0, 0,7));
    tbl.push_back(mk(0,1,0,32'h80,0, 0,0,0,0, 0,0,0,32'h80,0, 1,32'h55, 0,7));

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.cre, v.cwe, v.cadr, v.cwd, v.dreq, v.dwe, v.dadr, v.dwd);
      @(negedge clk);
      chk($sformatf("v%0d dma_gnt", i), dma_gnt, v.e_dgnt);
      chk($sformatf("v%0d cpu_stall", i), cpu_stall, v.e_stall);
      chk($sformatf("v%0d mem_we", i), mem_we, v.e_mwe);
      chk($sformatf("v%0d mem_adr", i), mem_adr, v.e_madr);
      if (v.e_mwe) chk($sformatf("v%0d mem_wd", i), mem_wd, v.e_mwd);
      if (v.chk_rd) chk($sformatf("v%0d cpu_rd", i), cpu_rd, v.e_rd);
      chk($sformatf("v%0d dma_rvalid", i), dma_rvalid, v.e_rv);
      chk($sformatf("v%0d dma_rdata", i), dma_rdata, v.e_rdata);
    end

    // ---------------- reset right after a DMA read grant ----------------
    drive(0, 0, 0, 0, 0, 1, 0, 32'h64, 0);
    @(negedge clk); chk("rstmid gnt", dma_gnt, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rstmid rvalid N+1", dma_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rstmid rvalid N+2", dma_rvalid, 0);
    chk("rstmid rdata", dma_rdata, 0);

    // ---------------- reset clears a partially used share ----------------
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 32'h0c, 0, 1, 0, 32'h10, 0);
      @(negedge clk); chk("pre-rst cpu wins", dma_gnt, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 32'h0c, 0, 1, 0, 32'h10, 0);
      @(negedge clk); chk($sformatf("post-rst share %0d", k), dma_gnt, k == 3);
    end

    // ---------------- randomized run against the reference model ----------------
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) refmem[i] = mem[i];
    wins = 0; m_rv = 0; m_rdata = '0; dma_wait = 0;
    begin
      logic c_hold, d_hold;
      c_hold = 0; d_hold = 0;
      reset = 0; cpu_re = 0; cpu_we = 0; dma_req = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        logic        e_cgnt, e_dgnt, creq, e_mwe;
        logic [31:0] e_madr, e_mwd;
        @(posedge clk);
        #1;
        // stalled core keeps its request; otherwise pick a new one
        if (!c_hold) begin
          int unsigned op;
          op = $urandom_range(0, 2);
          cpu_re  = (op == 1);
          cpu_we  = (op == 2);
          cpu_adr = 32'($urandom_range(0, 15)) << 2;
          cpu_wd  = $urandom;
        end
        if (d_hold) begin
          if ($urandom_range(0, 9) == 0) dma_req = 0;   // withdraw before grant
        end else begin
          dma_req = ($urandom_range(0, 1) == 1);
          dma_we  = ($urandom_range(0, 1) == 1);
          dma_adr = 32'($urandom_range(0, 15)) << 2;
          dma_wd  = $urandom;
        end

        creq = cpu_re | cpu_we;
        if (creq && dma_req) begin
          e_dgnt = (wins >= int'(SHARE));
          e_cgnt = !e_dgnt;
        end else begin
          e_cgnt = creq;
          e_dgnt = dma_req;
        end
        e_madr = e_dgnt ? dma_adr : cpu_adr;
        e_mwd  = e_dgnt ? dma_wd : cpu_wd;
        e_mwe  = (e_cgnt && cpu_we) || (e_dgnt && dma_we);

        @(negedge clk);
        chk("rnd dma_gnt", dma_gnt, e_dgnt);
        chk("rnd cpu_stall", cpu_stall, creq && !e_cgnt);
        chk("rnd mem_we", mem_we, e_mwe);
        chk("rnd mem_adr", mem_adr, e_madr);
        if (e_mwe) chk("rnd mem_wd", mem_wd, e_mwd);
        if (e_cgnt && cpu_re) chk("rnd cpu_rd", cpu_rd, refmem[cpu_adr[9:2]]);
        chk("rnd dma_rvalid", dma_rvalid, m_rv);
        chk("rnd dma_rdata", dma_rdata, m_rdata);
        if (e_dgnt) chk("rnd dma wait bound", dma_wait <= int'(SHARE), 1);

        // commit the cycle at the coming edge
        if (e_dgnt)             wins = 0;
        else if (creq && dma_req) wins++;
        m_rv = e_dgnt && !dma_we;
        if (e_dgnt && !dma_we) m_rdata = refmem[dma_adr[9:2]];
        if (e_mwe) refmem[e_madr[9:2]] = e_mwd;
        if (dma_req && !e_dgnt) dma_wait++; else dma_wait = 0;
        c_hold = creq && !e_cgnt;
        d_hold = dma_req && !e_dgnt;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
